// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one combinational ALU between two requesters,
// with a registered, handshaked response path and a completed-operation counter.

module alu_core #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [3:0]   i_op,
  output logic [N-1:0] o_y,
  output logic         o_err
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch inferred.
    o_y   = '0;
    o_err = 1'b0;
    case (i_op)
      4'd0: o_y = i_a + i_b;
      4'd1: o_y = i_a - i_b;
      4'd2: o_y = i_a * i_b;
      4'd3: begin
        if (i_b == '0) begin
          o_y   = '1;
          o_err = 1'b1;
        end else begin
          o_y = i_a / i_b;
        end
      end
      4'd4: o_y = i_a & i_b;
      4'd5: o_y = i_a | i_b;
      4'd6: o_y = ~i_a;
      4'd7: o_y = i_a << i_b;
      4'd8: o_y = i_a >> i_b;
      default: begin
        o_y   = '0;
        o_err = 1'b1;
      end
    endcase
  end

endmodule

module alu_scheduler #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [N-1:0]     rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [3:0]       r_op;
  logic             r_id;
  logic             r_rr_ptr;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic [N-1:0]     r_rsp_data;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_op_count;

  logic             w_idle;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_consume;
  logic [N-1:0]     w_alu_y;
  logic             w_alu_err;
  logic [N-1:0]     w_res_data;
  logic             w_res_err;

  assign w_idle = (r_state == S_IDLE);
  // The pointer only breaks ties; a lone valid requester always wins.
  assign w_gnt0 = req0_valid && (!req1_valid || !r_rr_ptr);
  assign w_gnt1 = req1_valid && (!req0_valid ||  r_rr_ptr);

  // Ready is masked by rst_n so every output reads 0 while reset is held.
  assign req0_ready = rst_n && w_idle && w_gnt0;
  assign req1_ready = rst_n && w_idle && w_gnt1;

  assign w_consume = r_id ? rsp1_ready : rsp0_ready;

  alu_core #(.N(N)) u_alu (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_op (r_op),
    .o_y  (w_alu_y),
    .o_err(w_alu_err)
  );

  // Illegal opcodes never expose ALU output, whatever the core returns.
  assign w_res_data = (r_op > 4'd8) ? '0   : w_alu_y;
  assign w_res_err  = (r_op > 4'd8) ? 1'b1 : w_alu_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_id         <= 1'b0;
      r_rr_ptr     <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_op_count   <= '0;
    end else begin
      // NOTE: non-blocking assignments; every register samples pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_a     <= w_gnt1 ? req1_a  : req0_a;
            r_b     <= w_gnt1 ? req1_b  : req0_b;
            r_op    <= w_gnt1 ? req1_op : req0_op;
            r_id    <= w_gnt1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data <= w_res_data;
          r_rsp_err  <= w_res_err;
          if (r_id) r_rsp1_valid <= 1'b1;
          else      r_rsp0_valid <= 1'b1;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_consume) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_op_count   <= r_op_count + CNT_W'(1);
            r_rr_ptr     <= ~r_id;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign busy       = !w_idle;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: a cycle-level protocol model checks the
// handshakes every cycle and queued expected results against each response.

module tb_alu_scheduler;

  localparam int N     = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [N-1:0]     req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_op, req1_op;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [N-1:0]     rsp_data;
  logic             rsp_err;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  alu_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_op   (req0_op),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_op   (req1_op),
    .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .op_count  (op_count)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: {err, data}
  function automatic logic [N:0] ref_alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [3:0] op);
    logic [N-1:0] y;
    case (op)
      4'd0: y = a + b;
      4'd1: y = a - b;
      4'd2: y = a * b;
      4'd3: begin
        if (b == 0) return {1'b1, {N{1'b1}}};
        y = a / b;
      end
      4'd4: y = a & b;
      4'd5: y = a | b;
      4'd6: y = ~a;
      4'd7: y = a << b;
      4'd8: y = a >> b;
      default: return {1'b1, {N{1'b0}}};
    endcase
    return {1'b0, y};
  endfunction

  typedef struct packed {
    logic         id;
    logic         err;
    logic [N-1:0] data;
  } rsp_t;

  typedef enum {M_IDLE, M_EXEC, M_RESP} mst_t;

  rsp_t             sb[$];
  mst_t             m_state = M_IDLE;
  logic             m_ptr = 1'b0;
  logic             m_id = 1'b0;
  logic [CNT_W-1:0] m_count = '0;

  // Protocol model: compare current outputs, then advance to the post-edge state.
  always @(negedge clk) begin : model
    logic e_g0, e_g1;
    rsp_t e;
    if (!rst_n) begin
      m_state = M_IDLE;
      m_ptr   = 1'b0;
      m_count = '0;
      sb.delete();
    end else begin
      e_g0 = (m_state == M_IDLE) && req0_valid && (!req1_valid || !m_ptr);
      e_g1 = (m_state == M_IDLE) && req1_valid && (!req0_valid ||  m_ptr);
      check("req0_ready", 32'(req0_ready), 32'(e_g0));
      check("req1_ready", 32'(req1_ready), 32'(e_g1));
      check("busy", 32'(busy), 32'(m_state != M_IDLE));
      check("rsp0_valid", 32'(rsp0_valid), 32'(m_state == M_RESP && !m_id));
      check("rsp1_valid", 32'(rsp1_valid), 32'(m_state == M_RESP &&  m_id));
      check("op_count", 32'(op_count), 32'(m_count));
      if (m_state == M_RESP) begin
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
          check("rsp_data", 32'(rsp_data), 32'(sb[0].data));
          check("rsp_err", 32'(rsp_err), 32'(sb[0].err));
        end
      end
      case (m_state)
        M_IDLE: begin
          if (e_g0 || e_g1) begin
            e.id = e_g1;
            {e.err, e.data} = e_g1 ? ref_alu(req1_a, req1_b, req1_op)
                                   : ref_alu(req0_a, req0_b, req0_op);
            sb.push_back(e);
            m_id    = e_g1;
            m_state = M_EXEC;
          end
        end
        M_EXEC: m_state = M_RESP;
        M_RESP: begin
          if (m_id ? rsp1_ready : rsp0_ready) begin
            if (sb.size() > 0) void'(sb.pop_front());
            m_count = m_count + 1'b1;
            m_ptr   = !m_id;
            m_state = M_IDLE;
          end
        end
        default: m_state = M_IDLE;
      endcase
    end
  end

  logic rand_mode = 1'b0;
  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present a request and hold it until granted; returns 1ns after the accept edge.
  task automatic issue(input bit id, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [3:0] op);
    bit got = 1'b0;
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("issue_grant", 32'(got), 1);
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp0_valid", 32'(rsp0_valid), 0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_op_count", 32'(op_count), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    rst_n = 1'b1;

    // Single request: 0x0F + 0x03
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    issue(1'b0, 8'h0F, 8'h03, 4'd0);
    @(posedge clk); #1;
    check("single_valid", 32'(rsp0_valid), 1);
    check("single_data", 32'(rsp_data), 32'(8'h12));
    check("single_err", 32'(rsp_err), 0);
    @(posedge clk); #1;
    check("single_count", 32'(op_count), 1);
    repeat (2) @(posedge clk);

    // Arbitration from reset with both requesters held valid
    do_reset();
    req0_a = 8'h0F; req0_b = 8'h03; req0_op = 4'd2;
    req1_a = 8'hF0; req1_b = 8'h0F; req1_op = 4'd1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("arb_first_valid", 32'(rsp0_valid), 1);
    check("arb_first_data", 32'(rsp_data), 32'(8'h2D));
    repeat (3) @(posedge clk); #1;
    check("arb_second_valid", 32'(rsp1_valid), 1);
    check("arb_second_data", 32'(rsp_data), 32'(8'hE1));
    repeat (6) @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Error cases
    issue(1'b0, 8'hF0, 8'h00, 4'd3);
    @(posedge clk); #1;
    check("div0_data", 32'(rsp_data), 32'(8'hFF));
    check("div0_err", 32'(rsp_err), 1);
    repeat (2) @(posedge clk); #1;
    issue(1'b1, 8'h12, 8'h34, 4'b1010);
    @(posedge clk); #1;
    check("badop_data", 32'(rsp_data), 0);
    check("badop_err", 32'(rsp_err), 1);
    repeat (2) @(posedge clk); #1;

    // Backpressure on requester 0 while requester 1 waits
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    issue(1'b0, 8'h55, 8'h0F, 4'd4);
    req1_a = 8'h30; req1_b = 8'h03; req1_op = 4'd5; req1_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(rsp0_valid), 1);
      check("bp_data", 32'(rsp_data), 32'(8'h05));
      check("bp_req1_ready", 32'(req1_ready), 0);
    end
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_req1_grant", 32'(req1_ready), 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Reset in EXEC: pointer would otherwise favour requester 1
    issue(1'b0, 8'h01, 8'h01, 4'd0);
    repeat (3) @(posedge clk); #1;
    issue(1'b1, 8'h07, 8'h02, 4'd7);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_rsp0_valid", 32'(rsp0_valid), 0);
    check("mid_rst_rsp1_valid", 32'(rsp1_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_op_count", 32'(op_count), 0);
    check("mid_rst_req0_ready", 32'(req0_ready), 0);
    check("mid_rst_req1_ready", 32'(req1_ready), 0);
    check("mid_rst_rsp_data", 32'(rsp_data), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req0_ready", 32'(req0_ready), 1);
    check("post_rst_req1_ready", 32'(req1_ready), 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (6) @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Counter wrap with CNT_W = 2
    do_reset();
    for (int i = 0; i < 5; i++) begin
      issue(1'(i), 8'(i), 8'h03, 4'(i));
      repeat (2) @(posedge clk); #1;
      check("wrap_count", 32'(op_count), (i + 1) % 4);
    end

    // Random traffic with random response backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 9)),
            4'($urandom_range(0, 11)));
    end
    rand_mode = 1'b0;
    @(posedge clk); #2;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
